// File: rtl/item_memory_multiport_top.sv
// Multi-channel item-memory front end: per-channel stage register plus hold FIFO, with
// IM-mode channels sharing a single lookup port through a round-robin arbiter.
module item_memory_multiport_top #(
   parameter int HVDimension   = 512,
   parameter int NumTotIm      = 1024,
   parameter int NumPorts      = 4,
   parameter int HoldFifoDepth = 2,
   localparam int ImAddrWidth  = $clog2(NumTotIm)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   clr_i,
   input  logic                                   enable_i,
   input  logic [NumPorts-1:0]                    port_mode_i,
   input  logic [NumPorts-1:0][ImAddrWidth-1:0]   lowdim_data_i,
   input  logic [NumPorts-1:0][HVDimension-1:0]   highdim_data_i,
   input  logic [NumPorts-1:0]                    data_valid_i,
   output logic [NumPorts-1:0]                    data_ready_o,
   output logic                                   im_req_valid_o,
   output logic [ImAddrWidth-1:0]                 im_req_addr_o,
   input  logic [HVDimension-1:0]                 im_rsp_hv_i,
   output logic [NumPorts-1:0][HVDimension-1:0]   hv_o,
   output logic [NumPorts-1:0]                    hv_valid_o,
   input  logic [NumPorts-1:0]                    pop_i,
   output logic                                   stall_o,
   output logic [31:0]                            stall_cnt_o
);

   localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int FpW  = (HoldFifoDepth > 1) ? $clog2(HoldFifoDepth) : 1;
   localparam int CntW = $clog2(HoldFifoDepth + 1);
   localparam int OccW = CntW + 1;

   logic [PtrW-1:0]                                    rr_ptr_q, rr_ptr_d;
   logic [NumPorts-1:0]                                stage_valid_q, stage_valid_d;
   logic [NumPorts-1:0]                                stage_mode_q, stage_mode_d;
   logic [NumPorts-1:0][ImAddrWidth-1:0]               stage_idx_q, stage_idx_d;
   logic [NumPorts-1:0][HVDimension-1:0]               stage_hv_q, stage_hv_d;
   logic [NumPorts-1:0][HoldFifoDepth-1:0][HVDimension-1:0] fifo_mem_q, fifo_mem_d;
   logic [NumPorts-1:0][FpW-1:0]                       wr_ptr_q, wr_ptr_d;
   logic [NumPorts-1:0][FpW-1:0]                       rd_ptr_q, rd_ptr_d;
   logic [NumPorts-1:0][CntW-1:0]                      count_q, count_d;
   logic [31:0]                                        stall_cnt_q, stall_cnt_d;

   logic [NumPorts-1:0]   has_space_s, eligible_s, grant_s, ready_s, hs_s;
   logic [NumPorts-1:0]   push_s, pop_s, hv_valid_s;
   logic [PtrW-1:0]       grant_idx_s;
   logic                  found_s, im_valid_s, stall_s;
   logic [ImAddrWidth-1:0] im_addr_s;
   logic [HVDimension-1:0] push_data_s;

   function automatic logic [FpW-1:0] fifo_ptr_inc(input logic [FpW-1:0] p);
      return (p == FpW'(HoldFifoDepth - 1)) ? '0 : p + FpW'(1);
   endfunction

   // Credit check: an in-flight stage entry already owns a FIFO slot; a same-cycle pop earns nothing.
   always_comb begin
      for (int i = 0; i < NumPorts; i++) begin
         has_space_s[i] = (OccW'(count_q[i]) + OccW'(stage_valid_q[i])) < OccW'(HoldFifoDepth);
         eligible_s[i]  = data_valid_i[i] & ~port_mode_i[i] & enable_i & has_space_s[i] & ~rst_i & ~clr_i;
      end
   end

   // Round-robin search starting just after the last granted IM channel.
   always_comb begin
      grant_s     = '0;
      grant_idx_s = rr_ptr_q;
      found_s     = 1'b0;
      for (int k = 1; k <= NumPorts; k++) begin
         if (!found_s && eligible_s[(int'(rr_ptr_q) + k) % NumPorts]) begin
            grant_s[(int'(rr_ptr_q) + k) % NumPorts] = 1'b1;
            grant_idx_s = PtrW'((int'(rr_ptr_q) + k) % NumPorts);
            found_s     = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
      rr_ptr_d = found_s ? grant_idx_s : rr_ptr_q;
   end

   // Ready, handshake and stage capture.
   always_comb begin
      stage_mode_d = stage_mode_q;
      stage_idx_d  = stage_idx_q;
      stage_hv_d   = stage_hv_q;
      for (int i = 0; i < NumPorts; i++) begin
         if (port_mode_i[i]) begin
            ready_s[i] = enable_i & has_space_s[i] & ~rst_i & ~clr_i;
         end else begin
            ready_s[i] = grant_s[i];
         end
         hs_s[i] = ready_s[i] & data_valid_i[i];
         if (hs_s[i]) begin
            stage_mode_d[i] = port_mode_i[i];
            stage_idx_d[i]  = lowdim_data_i[i];
            stage_hv_d[i]   = highdim_data_i[i];
         end else begin
            stage_mode_d[i] = stage_mode_q[i];
         end
      end
      stage_valid_d = hs_s;
   end

   // Shared lookup: at most one IM stage is live since only one IM grant is issued per cycle.
   always_comb begin
      im_valid_s = 1'b0;
      im_addr_s  = '0;
      for (int i = 0; i < NumPorts; i++) begin
         if (stage_valid_q[i] && !stage_mode_q[i]) begin
            im_valid_s = 1'b1;
            im_addr_s  = im_addr_s | stage_idx_q[i];
         end else begin
            im_addr_s  = im_addr_s;
         end
      end
   end

   // Hold FIFO bookkeeping per channel.
   always_comb begin
      fifo_mem_d  = fifo_mem_q;
      push_data_s = '0;
      for (int i = 0; i < NumPorts; i++) begin
         push_s[i]   = stage_valid_q[i];
         pop_s[i]    = pop_i[i] & (count_q[i] != '0);
         push_data_s = stage_mode_q[i] ? stage_hv_q[i] : im_rsp_hv_i;
         if (push_s[i]) begin
            fifo_mem_d[i][wr_ptr_q[i]] = push_data_s;
         end else begin
            fifo_mem_d[i] = fifo_mem_q[i];
         end
         wr_ptr_d[i] = push_s[i] ? fifo_ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
         rd_ptr_d[i] = pop_s[i] ? fifo_ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
         count_d[i]  = count_q[i] + CntW'(push_s[i]) - CntW'(pop_s[i]);
         hv_valid_s[i] = (count_q[i] != '0) & ~rst_i;
      end
      stall_s     = (|(pop_i & ~hv_valid_s)) & ~rst_i;
      stall_cnt_d = (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   // Output drive; everything is forced quiet while reset is asserted.
   always_comb begin
      data_ready_o   = ready_s;
      im_req_valid_o = im_valid_s & ~rst_i;
      im_req_addr_o  = rst_i ? '0 : im_addr_s;
      hv_valid_o     = hv_valid_s;
      stall_o        = stall_s;
      stall_cnt_o    = stall_cnt_q;
      for (int i = 0; i < NumPorts; i++) begin
         hv_o[i] = hv_valid_s[i] ? fifo_mem_q[i][rd_ptr_q[i]] : '0;
      end
   end

   // Control state; clear flushes like reset but keeps the stall counter running.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q      <= PtrW'(NumPorts - 1);
         stage_valid_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         stall_cnt_q   <= 32'd0;
      end else if (clr_i) begin
         rr_ptr_q      <= PtrW'(NumPorts - 1);
         stage_valid_q <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         stall_cnt_q   <= stall_cnt_d;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         stage_valid_q <= stage_valid_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   // Datapath storage; contents are only observed through the valid/count state above.
   always_ff @(posedge clk_i) begin
      stage_mode_q <= stage_mode_d;
      stage_idx_q  <= stage_idx_d;
      stage_hv_q   <= stage_hv_d;
      fifo_mem_q   <= fifo_mem_d;
   end

endmodule
